// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered digits and inter-digit blanking.
// Optional build macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits while scanning).
module display_scan_ctrl #(
  parameter int N_DIGITS  = 6,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]     dp_in,
  output logic [N_DIGITS-1:0]     disp,
  output logic [6:0]              segm,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                slot_cnt_q, slot_cnt_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [N_DIGITS-1:0][3:0]     pending_q, pending_d;
  logic [N_DIGITS-1:0][3:0]     active_q, active_d;
  logic [N_DIGITS-1:0]          pending_dp_q, pending_dp_d;
  logic [N_DIGITS-1:0]          active_dp_q, active_dp_d;
  logic [N_DIGITS-1:0]          disp_q, disp_d;
  logic [6:0]                   segm_q, segm_d;
  logic                         dp_q, dp_d;
  logic                         frame_done_q, frame_done_d;
  logic                         wrap;
  logic [N_DIGITS-1:0]          lz_mask;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Scan sequencing and buffer management
  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    idx_d        = idx_q;
    pending_d    = pending_q;
    pending_dp_d = pending_dp_q;
    active_d     = active_q;
    active_dp_d  = active_dp_q;
    wrap         = 1'b0;

    if (load) begin
      pending_d    = digits_in;
      pending_dp_d = dp_in;
    end

    if (!en) begin
      state_d    = IDLE;
      slot_cnt_d = '0;
      idx_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = BLANK;
          slot_cnt_d = '0;
        end
        BLANK: begin
          slot_cnt_d = slot_cnt_q + CW'(1);
          if (slot_cnt_q == BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (slot_cnt_q == SLOT_LAST) begin
            state_d    = BLANK;
            slot_cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            slot_cnt_d = slot_cnt_q + CW'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          slot_cnt_d = '0;
          idx_d      = '0;
        end
      endcase
    end

    // pending_d already holds a same-edge load, so a load on the wrap goes straight to active
    if (wrap) begin
      active_d    = pending_d;
      active_dp_d = pending_dp_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic run;
    lz_mask = '0;
    run     = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      run        = run & (active_d[k] == 4'd0);
      lz_mask[k] = run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Outputs are decoded from next-state values so the registered outputs line up with the state
  always_comb begin
    disp_d       = '1;
    segm_d       = 7'h7F;
    dp_d         = 1'b1;
    frame_done_d = 1'b0;
    if (state_d == SHOW) begin
      disp_d[idx_d] = 1'b0;
      segm_d        = lz_mask[idx_d] ? 7'h7F : hex7(active_d[idx_d]);
      dp_d          = ~active_dp_d[idx_d];
      frame_done_d  = (slot_cnt_d == SLOT_LAST) && (idx_d == IDX_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      pending_q    <= '0;
      pending_dp_q <= '0;
      active_q     <= '0;
      active_dp_q  <= '0;
      disp_q       <= '1;
      segm_q       <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      pending_dp_q <= pending_dp_d;
      active_q     <= active_d;
      active_dp_q  <= active_dp_d;
      disp_q       <= disp_d;
      segm_q       <= segm_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign disp       = disp_q;
  assign segm       = segm_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl: directed scenarios then random traffic, checked every cycle
// against a time-based reference model (scan position derived from cycles since enable).
module tb_display_scan_ctrl;
  localparam int N     = 6;
  localparam int SLOT  = 4;
  localparam int BLANK = 1;
  localparam int FRAME = N * SLOT;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic           load = 1'b0;
  logic [4*N-1:0] digits_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [N-1:0]   disp;
  logic [6:0]     segm;
  logic           dp;
  logic           frame_done;

  int checks = 0;
  int failures = 0;

  // reference model: scan position is a pure function of cycles since the scan (re)started
  bit             m_on;
  int             m_t;
  logic [4*N-1:0] m_pend, m_act;
  logic [N-1:0]   m_pdp, m_adp;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  display_scan_ctrl #(.N_DIGITS(N), .SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .disp(disp), .segm(segm), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, got, exp, m_t);
    end
  endtask

  function automatic bit lead_blank(input int slot);
`ifdef LEADING_ZERO_BLANK_EN
    return (slot != 0) && ((m_act >> (slot * 4)) == '0);
`else
    return (slot < 0);
`endif
  endfunction

  task automatic step();
    bit             wrap;
    int             slot, ph;
    logic [N-1:0]   e_disp;
    logic [6:0]     e_segm;
    logic           e_dp, e_fd;
    logic [3:0]     d;
    @(posedge clk);
    if (!rst) begin
      m_on = 0; m_t = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
    end else begin
      wrap = m_on && en && (m_t % FRAME == FRAME - 1);
      if (load) begin m_pend = digits_in; m_pdp = dp_in; end
      if (wrap) begin m_act = m_pend; m_adp = m_pdp; end
      if (en) begin
        if (m_on) m_t++;
        else begin m_on = 1; m_t = 0; end
      end else begin
        m_on = 0;
      end
    end
    #1;
    e_disp = '1; e_segm = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    if (m_on) begin
      slot = (m_t / SLOT) % N;
      ph   = m_t % SLOT;
      if (ph >= BLANK) begin
        e_disp[slot] = 1'b0;
        d = m_act[slot*4 +: 4];
        e_segm = lead_blank(slot) ? 7'h7F : seg_tab[d];
        e_dp = ~m_adp[slot];
      end
      e_fd = (m_t % FRAME == FRAME - 1);
    end
    check("disp", 32'(disp), 32'(e_disp));
    check("segm", 32'(segm), 32'(e_segm));
    check("dp", 32'(dp), 32'(e_dp));
    check("frame_done", 32'(frame_done), 32'(e_fd));
  endtask

  task automatic run_to(input int t);
    int n = 0;
    while (!(m_on && m_t == t) && n < 200) begin
      step();
      n++;
    end
    checks++;
    assert (m_on && m_t == t) else begin
      failures++;
      $error("FAIL run_to observed_t=%0d expected_t=%0d", m_t, t);
    end
  endtask

  initial begin
    m_on = 0; m_t = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;

    // reset held with en=1
    rst = 1'b0; en = 1'b1;
    repeat (3) begin
      step();
      check("rst_disp", 32'(disp), 32'h3F);
      check("rst_segm", 32'(segm), 32'h7F);
    end

    // scan order: first frame shows zeros, second frame shows 654321
    rst = 1'b1; load = 1'b1; digits_in = 24'h654321; dp_in = '0;
    step();
    load = 1'b0;
    run_to(FRAME - 1);
    check("fd_first", 32'(frame_done), 32'h1);
    run_to(FRAME + 1);
    check("scan0_disp", 32'(disp), 32'h3E);
    check("scan0_segm", 32'(segm), 32'h79);
    run_to(FRAME + 5);
    check("scan1_disp", 32'(disp), 32'h3D);
    check("scan1_segm", 32'(segm), 32'h24);
    run_to(2 * FRAME - 1);
    check("scan5_disp", 32'(disp), 32'h1F);
    check("scan5_segm", 32'(segm), 32'h02);
    check("fd_second", 32'(frame_done), 32'h1);

    // double buffer: mid-frame load waits for the wrap
    run_to(50);
    load = 1'b1; digits_in = 24'h000009;
    step();
    load = 1'b0;
    run_to(53);
    check("dbuf_old_segm", 32'(segm), 32'h24);
    run_to(3 * FRAME + 1);
    check("dbuf_new_segm", 32'(segm), 32'h10);

    // load coinciding with the wrap is visible in the very next frame
    run_to(4 * FRAME - 1);
    load = 1'b1; digits_in = 24'h00000A;
    step();
    load = 1'b0;
    run_to(4 * FRAME + 1);
    check("wrapload_segm", 32'(segm), 32'h08);

    // enable drop during SHOW of idx 3, then restart
    run_to(4 * FRAME + 3 * SLOT + 2);
    en = 1'b0;
    step();
    check("endrop_disp", 32'(disp), 32'h3F);
    check("endrop_segm", 32'(segm), 32'h7F);
    en = 1'b1;
    step();
    check("restart_blank", 32'(disp), 32'h3F);
    step();
    check("restart_disp", 32'(disp), 32'h3E);

    // decimal point on idx 2
    load = 1'b1; digits_in = 24'h123456; dp_in = 6'b000100;
    step();
    load = 1'b0; dp_in = '0;
    run_to(FRAME + 2 * SLOT);
    check("dp_blank", 32'(dp), 32'h1);
    run_to(FRAME + 2 * SLOT + 1);
    check("dp_show", 32'(dp), 32'h0);
    run_to(FRAME + 3 * SLOT + 1);
    check("dp_other", 32'(dp), 32'h1);

    // leading zeros
    load = 1'b1; digits_in = 24'h000050; dp_in = '0;
    step();
    load = 1'b0;
    run_to(2 * FRAME + 1);
    check("lz_idx0", 32'(segm), 32'h40);
    run_to(2 * FRAME + SLOT + 1);
    check("lz_idx1", 32'(segm), 32'h12);
    run_to(2 * FRAME + 3 * SLOT + 1);
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_idx3", 32'(segm), 32'h7F);
`else
    check("lz_idx3", 32'(segm), 32'h40);
`endif

    // random traffic, including mid-frame reset and en toggling
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 299) != 0);
      en        = ($urandom_range(0, 39) != 0);
      load      = ($urandom_range(0, 14) == 0);
      digits_in = 24'($urandom);
      dp_in     = 6'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
